// File: rtl/circle_cmd_queue_if.sv
// rtl/circle_cmd_queue_if.sv - command intake and circle engine handshake bundle
//
// Purpose: groups the command valid/ready bus and the circle engine
// start/done bus of circle_cmd_queue into one interface.
//   master : the side that issues commands and hosts the circle engine
//   slave  : the command queue itself
// Signals:
//   cmd_valid, cmd_ready                        command handshake
//   cmd_colour, cmd_centre_x, cmd_centre_y,
//   cmd_radius                                  command payload
//   circ_start, circ_done                       engine level handshake
//   circ_colour, circ_centre_x, circ_centre_y,
//   circ_radius                                 held payload for the engine
interface circle_cmd_queue_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_colour;
  logic [7:0] cmd_centre_x;
  logic [6:0] cmd_centre_y;
  logic [7:0] cmd_radius;

  logic       circ_start;
  logic [2:0] circ_colour;
  logic [7:0] circ_centre_x;
  logic [6:0] circ_centre_y;
  logic [7:0] circ_radius;
  logic       circ_done;

  modport master (
    output cmd_valid, cmd_colour, cmd_centre_x, cmd_centre_y, cmd_radius,
    input  cmd_ready,
    input  circ_start, circ_colour, circ_centre_x, circ_centre_y, circ_radius,
    output circ_done
  );

  modport slave (
    input  cmd_valid, cmd_colour, cmd_centre_x, cmd_centre_y, cmd_radius,
    output cmd_ready,
    output circ_start, circ_colour, circ_centre_x, circ_centre_y, circ_radius,
    input  circ_done
  );
endinterface

// File: rtl/circle_cmd_queue.sv
// rtl/circle_cmd_queue.sv - buffered command queue and dispatcher for the circle rasteriser
//
// Purpose: accepts circle draw commands into a DEPTH-entry FIFO and hands
// them one at a time to the circle engine over a level start/done
// handshake, waiting for done to drop before issuing the next command.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        circle_cmd_queue_if.slave (command intake + engine handshake)
//   level      FIFO occupancy, 0..DEPTH
//   busy       dispatcher not idle or FIFO non-empty
//   completed  finished command count, wraps modulo 2^CNT_W
// Parameters:
//   DEPTH      FIFO entries, power of two, >= 2
//   CNT_W      width of the completed counter
// Optional feature macro: SKIP_ZERO_RADIUS_EN
//   When defined, radius-0 commands are retired straight from the FIFO
//   head without being dispatched to the engine.
module circle_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  circle_cmd_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic [CNT_W-1:0]       completed
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 26;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t         state;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [EW-1:0]  hold;
  logic           start_q;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [EW-1:0]  head;
  logic [EW-1:0]  entry;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign entry = {bus.cmd_colour, bus.cmd_centre_x, bus.cmd_centre_y, bus.cmd_radius};
  assign head  = mem[rd_ptr];

  // Ready depends on occupancy only, never on cmd_valid or the pop decision.
  assign push = bus.cmd_valid && !full;
  // Every IDLE visit with a non-empty FIFO consumes the head, whether it is
  // dispatched or (with the skip feature) retired in place.
  assign pop  = (state == IDLE) && !empty;

  assign bus.cmd_ready     = !full;
  assign bus.circ_start    = start_q;
  assign bus.circ_colour   = hold[25:23];
  assign bus.circ_centre_x = hold[22:15];
  assign bus.circ_centre_y = hold[14:8];
  assign bus.circ_radius   = hold[7:0];

  assign level = count;
  assign busy  = (state != IDLE) || !empty;

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      start_q   <= 1'b0;
      hold      <= '0;
      completed <= '0;
    end else begin
      // Pointers are AW bits wide, so DEPTH being a power of two makes the
      // natural overflow the modulo-DEPTH wrap.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          start_q <= 1'b0;
          if (!empty) begin
`ifdef SKIP_ZERO_RADIUS_EN
            if (head[7:0] == 8'd0) begin
              completed <= completed + CNT_W'(1);
            end else begin
              hold    <= head;
              state   <= RUN;
              start_q <= 1'b1;
            end
`else
            hold    <= head;
            state   <= RUN;
            start_q <= 1'b1;
`endif
          end
        end
        RUN: begin
          if (bus.circ_done) begin
            state   <= RELEASE;
            start_q <= 1'b0;
          end
        end
        RELEASE: begin
          start_q <= 1'b0;
          // The engine must drop done before the next command may start.
          if (!bus.circ_done) begin
            state     <= IDLE;
            completed <= completed + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circle_cmd_queue.sv
// tb/tb_circle_cmd_queue.sv - scoreboard bench for circle_cmd_queue
module tb_circle_cmd_queue;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  circle_cmd_queue_if bus();
  logic [$clog2(DEPTH):0] level;
  logic                   busy;
  logic [CNT_W-1:0]       completed;

  circle_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .level(level),
    .busy(busy),
    .completed(completed)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_completed = 0;
  logic [25:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] circ_word();
    return {bus.circ_colour, bus.circ_centre_x, bus.circ_centre_y, bus.circ_radius};
  endfunction

  function automatic logic [25:0] rand_cmd();
    logic [25:0] v;
    v = 26'($urandom);
    v[7:0] = v[7:0] | 8'd1;
    return v;
  endfunction

  task automatic set_cmd(input logic [25:0] c);
    {bus.cmd_colour, bus.cmd_centre_x, bus.cmd_centre_y, bus.cmd_radius} = c;
  endtask

  task automatic push_cmd(input logic [25:0] c);
    set_cmd(c);
    bus.cmd_valid = 1'b1;
    if (bus.cmd_ready === 1'b1) begin
`ifdef SKIP_ZERO_RADIUS_EN
      if (c[7:0] != 8'd0) sb.push_back(c);
`else
      sb.push_back(c);
`endif
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Circle engine stub: waits for start, holds it run_cycles, raises done
  // until start drops, keeps done high hold_cycles more, then drops it.
  task automatic engine(input int run_cycles, input int hold_cycles,
                        output logic [25:0] got, output int t_start,
                        output int t_fall, output bit ok);
    int n;
    ok = 1'b0; got = '0; t_start = 0; t_fall = 0;
    n = 0;
    while (bus.circ_start !== 1'b1 && n < 100) begin tick(); n++; end
    if (bus.circ_start !== 1'b1) return;
    t_start = cyc;
    got = circ_word();
    repeat (run_cycles) tick();
    bus.circ_done = 1'b1;
    n = 0;
    while (bus.circ_start !== 1'b0 && n < 100) begin tick(); n++; end
    if (bus.circ_start !== 1'b0) begin bus.circ_done = 1'b0; return; end
    t_fall = cyc;
    repeat (hold_cycles) tick();
    bus.circ_done = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.circ_done = 1'b0;
    set_cmd('0);
    tick(); tick();
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready); end
    vectors++; if (level !== '0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", level); end
    vectors++; if (bus.circ_start !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b expected 0", bus.circ_start); end
    vectors++; if (circ_word() !== 26'h0) begin miscompares++; $display("FAIL reset_circ_data: got %h expected 0", circ_word()); end
    vectors++; if (completed !== '0) begin miscompares++; $display("FAIL reset_completed: got %0d expected 0", completed); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    sb.delete();
    exp_completed = 0;
    tick();
  endtask

  task automatic test_single;
    logic [25:0] exp;
    push_cmd({3'b100, 8'd80, 7'd60, 8'd10});
    vectors++; if (bus.circ_start !== 1'b0 || level !== 1) begin miscompares++; $display("FAIL single_cycle1: got start=%b level=%0d expected start=0 level=1", bus.circ_start, level); end
    tick();
    vectors++; if (bus.circ_start !== 1'b1) begin miscompares++; $display("FAIL single_start_latency: got %b expected 1", bus.circ_start); end
    exp = sb.pop_front();
    vectors++; if (circ_word() !== exp) begin miscompares++; $display("FAIL single_held_data: got %h expected %h", circ_word(), exp); end
    vectors++; if (level !== 0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_run_status: got level=%0d busy=%b expected level=0 busy=1", level, busy); end
    repeat (18) tick();
    vectors++; if (bus.circ_start !== 1'b1 || circ_word() !== exp) begin miscompares++; $display("FAIL single_run_stable: got start=%b data=%h expected start=1 data=%h", bus.circ_start, circ_word(), exp); end
    bus.circ_done = 1'b1;
    tick();
    vectors++; if (bus.circ_start !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_release: got start=%b busy=%b expected start=0 busy=1", bus.circ_start, busy); end
    tick();
    vectors++; if (completed !== CNT_W'(exp_completed)) begin miscompares++; $display("FAIL single_completed_early: got %0d expected %0d", completed, exp_completed); end
    bus.circ_done = 1'b0;
    tick();
    exp_completed++;
    vectors++; if (completed !== CNT_W'(exp_completed) || busy !== 1'b0) begin miscompares++; $display("FAIL single_done: got completed=%0d busy=%b expected completed=%0d busy=0", completed, busy, exp_completed); end
  endtask

  task automatic test_fill;
    logic [25:0] c, got, exp;
    int ts, tf;
    bit ok, exp_ready;
    bus.circ_done = 1'b0;
    for (int i = 0; i <= DEPTH + 1; i++) begin
      c = rand_cmd();
      set_cmd(c);
      bus.cmd_valid = 1'b1;
      exp_ready = (i <= DEPTH);
      vectors++; if (bus.cmd_ready !== exp_ready) begin miscompares++; $display("FAIL fill_ready_%0d: got %b expected %b", i, bus.cmd_ready, exp_ready); end
      if (bus.cmd_ready === 1'b1) sb.push_back(c);
      tick();
    end
    repeat (3) tick();
    vectors++; if (level !== DEPTH || bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL fill_saturate: got level=%0d ready=%b expected level=%0d ready=0", level, bus.cmd_ready, DEPTH); end
    vectors++; if (completed !== CNT_W'(exp_completed)) begin miscompares++; $display("FAIL fill_completed: got %0d expected %0d", completed, exp_completed); end
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      engine(2, 0, got, ts, tf, ok);
      exp = (sb.size() != 0) ? sb.pop_front() : 26'h0;
      vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL fill_drain_%0d: got %h ok=%0d expected %h", k, got, ok, exp); end
      exp_completed++;
    end
    tick();
    vectors++; if (completed !== CNT_W'(exp_completed) || level !== 0 || busy !== 1'b0) begin miscompares++; $display("FAIL fill_end: got completed=%0d level=%0d busy=%b expected %0d 0 0", completed, level, busy, exp_completed); end
  endtask

  task automatic test_three;
    logic [25:0] got, exp;
    int ts, tf, prev_tf;
    bit ok;
    prev_tf = 0;
    for (int i = 0; i < 3; i++) push_cmd(rand_cmd());
    for (int k = 0; k < 3; k++) begin
      engine(5, 0, got, ts, tf, ok);
      exp = (sb.size() != 0) ? sb.pop_front() : 26'h0;
      vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL three_dispatch_%0d: got %h ok=%0d expected %h", k, got, ok, exp); end
      if (k > 0) begin
        vectors++; if (ts - prev_tf < 2) begin miscompares++; $display("FAIL three_gap_%0d: got %0d low cycles expected >= 2", k, ts - prev_tf); end
      end
      prev_tf = tf;
      exp_completed++;
    end
    tick();
    vectors++; if (completed !== CNT_W'(exp_completed)) begin miscompares++; $display("FAIL three_completed: got %0d expected %0d", completed, exp_completed); end
  endtask

  task automatic test_release_hold;
    logic [25:0] exp;
    int n;
    push_cmd(rand_cmd());
    n = 0;
    while (bus.circ_start !== 1'b1 && n < 100) begin tick(); n++; end
    exp = (sb.size() != 0) ? sb.pop_front() : 26'h0;
    vectors++; if (bus.circ_start !== 1'b1 || circ_word() !== exp) begin miscompares++; $display("FAIL hold_dispatch: got start=%b data=%h expected start=1 data=%h", bus.circ_start, circ_word(), exp); end
    tick();
    bus.circ_done = 1'b1;
    tick();
    for (int j = 0; j < 4; j++) begin
      vectors++; if (bus.circ_start !== 1'b0 || completed !== CNT_W'(exp_completed) || circ_word() !== exp) begin miscompares++; $display("FAIL hold_release_%0d: got start=%b completed=%0d data=%h expected 0 %0d %h", j, bus.circ_start, completed, circ_word(), exp_completed, exp); end
      tick();
    end
    bus.circ_done = 1'b0;
    tick();
    exp_completed++;
    vectors++; if (completed !== CNT_W'(exp_completed) || bus.circ_start !== 1'b0) begin miscompares++; $display("FAIL hold_complete: got completed=%0d start=%b expected %0d 0", completed, bus.circ_start, exp_completed); end
  endtask

  task automatic test_reset_mid;
    int n;
    for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
    n = 0;
    while (bus.circ_start !== 1'b1 && n < 100) begin tick(); n++; end
    vectors++; if (bus.circ_start !== 1'b1 || level !== 3) begin miscompares++; $display("FAIL rstmid_pre: got start=%b level=%0d expected 1 3", bus.circ_start, level); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    exp_completed = 0;
    vectors++; if (bus.circ_start !== 1'b0 || level !== 0 || completed !== '0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_state: got start=%b level=%0d completed=%0d ready=%b busy=%b expected 0 0 0 1 0", bus.circ_start, level, completed, bus.cmd_ready, busy); end
    tick();
    vectors++; if (bus.circ_start !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_dispatch: got %b expected 0", bus.circ_start); end
  endtask

  task automatic test_zero_radius;
    logic [25:0] c0, c1, got, exp;
    int ts, tf, n_disp;
    bit ok, extra;
    c0 = rand_cmd(); c0[7:0] = 8'd0;
    c1 = rand_cmd(); c1[7:0] = 8'd5;
    push_cmd(c0);
    push_cmd(c1);
`ifdef SKIP_ZERO_RADIUS_EN
    n_disp = 1;
`else
    n_disp = 2;
`endif
    for (int k = 0; k < n_disp; k++) begin
      engine(3, 0, got, ts, tf, ok);
      exp = (sb.size() != 0) ? sb.pop_front() : 26'h0;
      vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL zero_dispatch_%0d: got %h ok=%0d expected %h", k, got, ok, exp); end
    end
    exp_completed += 2;
    tick();
    vectors++; if (completed !== CNT_W'(exp_completed)) begin miscompares++; $display("FAIL zero_completed: got %0d expected %0d", completed, exp_completed); end
    extra = 1'b0;
    repeat (10) begin
      if (bus.circ_start === 1'b1) extra = 1'b1;
      tick();
    end
    vectors++; if (extra !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_no_extra: got extra_start=%b busy=%b expected 0 0", extra, busy); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.circ_done = 1'b0;
    set_cmd('0);
    test_reset();
    test_single();
    test_fill();
    test_three();
    test_release_hold();
    test_zero_radius();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
